// File: rtl/pulse_slot_sched_pkg.sv
// Shared types and defaults for the pulse slot scheduler and its helpers.
package pulse_slot_sched_pkg;

    localparam int N_CH_DEF  = 8;
    localparam int CH_W_DEF  = 3;
    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 16;

    // A zero window would never count; it is stretched to this many cycles.
    localparam int WIN_ZERO_LOAD = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COUNT,
        ST_CAPTURE,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/pulse_slot_sched_if.sv
// Counter-control and result handshake bundle between the scheduler and its neighbours.
interface pulse_slot_sched_if
    import pulse_slot_sched_pkg::*;
#(
    parameter int CH_W  = CH_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic [CH_W-1:0]  cnt_sel;
    logic             cnt_clear;
    logic             cnt_enable;
    logic [CNT_W-1:0] cnt_value;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_data;
    logic [CH_W-1:0]  res_ch;

    modport master (
        output cnt_sel, cnt_clear, cnt_enable, res_valid, res_data, res_ch,
        input  cnt_value, res_ready
    );

    modport slave (
        input  cnt_sel, cnt_clear, cnt_enable, res_valid, res_data, res_ch,
        output cnt_value, res_ready
    );

endinterface

// File: rtl/pulse_slot_sched_rr_pick.sv
// Combinational round-robin finder: first set mask bit strictly after last_i, wrapping.
module pulse_slot_sched_rr_pick #(
    parameter int N_CH = 8,
    parameter int CH_W = 3
) (
    input  logic [N_CH-1:0] mask_i,
    input  logic [CH_W-1:0] last_i,
    output logic [CH_W-1:0] next_o,
    output logic            any_o
);

    logic            found;
    logic [CH_W-1:0] idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (that would infer a latch).
        next_o = '0;
        any_o  = |mask_i;
        found  = 1'b0;
        idx    = '0;
        for (int off = 1; off <= N_CH; off++) begin
            idx = CH_W'((int'(last_i) + off) % N_CH);
            if (!found && mask_i[idx]) begin
                next_o = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_slot_sched.sv
// Round-robin time-slot scheduler sharing one Gray pulse counter among N_CH input lines.
module pulse_slot_sched
    import pulse_slot_sched_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CH_W  = CH_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [N_CH-1:0]       ch_mask,
    input  logic [WIN_W-1:0]      window_len,
    output logic                  busy,
    pulse_slot_sched_if.master    bus
);

    state_e            state_q;
    logic [CH_W-1:0]   sel_q;
    logic [CH_W-1:0]   last_q;
    logic [WIN_W-1:0]  win_q;
    logic [CNT_W-1:0]  data_q;
    logic              valid_q;
    logic              clear_q;
    logic              enable_q;
    logic              busy_q;

    logic [CH_W-1:0]   pick_d;
    logic              any_d;
    logic              start_d;
    logic              launch_d;
    logic [WIN_W-1:0]  win_load_d;

    pulse_slot_sched_rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .mask_i (ch_mask),
        .last_i (last_q),
        .next_o (pick_d),
        .any_o  (any_d)
    );

    assign start_d    = run && any_d;
    assign launch_d   = start_d && ((state_q == ST_IDLE) ||
                                    (state_q == ST_HOLD && bus.res_ready));
    assign win_load_d = (window_len == '0) ? WIN_W'(WIN_ZERO_LOAD) : window_len;

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments; the launch block below relies on the last NBA to a register winning.
        if (reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            last_q   <= CH_W'(N_CH - 1);
            win_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            clear_q  <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_CLEAR: begin
                    clear_q  <= 1'b0;
                    enable_q <= 1'b1;
                    state_q  <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (win_q == WIN_W'(1)) begin
                        enable_q <= 1'b0;
                        state_q  <= ST_CAPTURE;
                    end else begin
                        win_q <= win_q - WIN_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    data_q  <= bus.cnt_value;
                    last_q  <= sel_q;
                    valid_q <= 1'b1;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A new slot starts from IDLE or straight out of an accepted HOLD.
            if (launch_d) begin
                state_q <= ST_CLEAR;
                sel_q   <= pick_d;
                win_q   <= win_load_d;
                clear_q <= 1'b1;
                busy_q  <= 1'b1;
            end
        end
    end

    assign bus.cnt_sel    = sel_q;
    assign bus.res_ch     = sel_q;
    assign bus.cnt_clear  = clear_q;
    assign bus.cnt_enable = enable_q;
    assign bus.res_valid  = valid_q;
    assign bus.res_data   = data_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_pulse_slot_sched.sv
// Self-checking bench: slot-timeline model compared every cycle, plus directed literal checks.
module tb_pulse_slot_sched;

    localparam int N_CH  = 8;
    localparam int CH_W  = 3;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [N_CH-1:0]  ch_mask;
    logic [WIN_W-1:0] window_len;
    logic             busy;
    logic [N_CH-1:0]  pulses;

    pulse_slot_sched_if #(.CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    pulse_slot_sched #(
        .N_CH (N_CH),
        .CH_W (CH_W),
        .CNT_W(CNT_W),
        .WIN_W(WIN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .ch_mask   (ch_mask),
        .window_len(window_len),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Behavioural pulse counter the scheduler drives: binary count, Gray output.
    logic [CNT_W-1:0] env_bin = '0;
    always @(posedge clk) begin
        if (bus.cnt_clear === 1'b1)
            env_bin <= '0;
        else if (bus.cnt_enable === 1'b1 && pulses[bus.cnt_sel] === 1'b1)
            env_bin <= env_bin + 1'b1;
    end
    assign bus.cnt_value = env_bin ^ (env_bin >> 1);

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int gray(input int n);
        return n ^ (n >> 1);
    endfunction

    // Transfer monitor
    int cyc = 0;
    int mon_ch[$];
    int mon_data[$];
    int mon_cyc[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            mon_ch.push_back(int'(bus.res_ch));
            mon_data.push_back(int'(bus.res_data));
            mon_cyc.push_back(cyc);
        end
    end

    // Slot model: position within a slot is an offset from the CLEAR cycle.
    bit m_known = 1'b0;
    bit m_slot  = 1'b0;
    int m_off, m_win, m_cnt;
    int m_ch   = 0;
    int m_last = N_CH - 1;
    int m_data = 0;

    task automatic start_slot();
        for (int k = 1; k <= N_CH; k++) begin
            int c;
            c = (m_last + k) % N_CH;
            if (ch_mask[c]) begin
                m_ch = c;
                break;
            end
        end
        m_last = m_ch;
        m_win  = (window_len == 0) ? 1 : int'(window_len);
        m_off  = 0;
        m_cnt  = 0;
        m_slot = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_known) begin
                check("cyc_cnt_sel",    bus.cnt_sel,    m_ch);
                check("cyc_res_ch",     bus.res_ch,     m_ch);
                check("cyc_res_data",   bus.res_data,   m_data);
                check("cyc_busy",       busy,           m_slot);
                check("cyc_cnt_clear",  bus.cnt_clear,  m_slot && m_off == 0);
                check("cyc_cnt_enable", bus.cnt_enable, m_slot && m_off >= 1 && m_off <= m_win);
                check("cyc_res_valid",  bus.res_valid,  m_slot && m_off >= m_win + 2);
            end
            if (reset) begin
                m_known = 1'b1;
                m_slot  = 1'b0;
                m_last  = N_CH - 1;
                m_ch    = 0;
                m_data  = 0;
            end else if (m_known) begin
                if (m_slot) begin
                    if (m_off >= 1 && m_off <= m_win && pulses[m_ch]) m_cnt++;
                    if (m_off == m_win + 1) m_data = gray(m_cnt);
                    if (m_off >= m_win + 2 && bus.res_ready) begin
                        if (run && ch_mask != 0) start_slot();
                        else m_slot = 1'b0;
                    end else begin
                        m_off++;
                    end
                end else if (run && ch_mask != 0) begin
                    start_slot();
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        mon_ch.delete();
        mon_data.delete();
        mon_cyc.delete();
    endtask

    task automatic wait_clear(input int budget);
        for (int i = 0; i < budget && bus.cnt_clear !== 1'b1; i++) tick();
        check("clear_seen", bus.cnt_clear, 1);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && bus.res_valid !== 1'b1; i++) tick();
        check("valid_seen", bus.res_valid, 1);
    endtask

    task automatic wait_xfers(input int n, input int budget);
        for (int i = 0; i < budget && mon_ch.size() < n; i++) tick();
        check("xfer_count", mon_ch.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy !== 1'b0; i++) tick();
        check("idle_reached", busy, 0);
    endtask

    int exp_ch[5] = '{0, 1, 7, 0, 1};
    int exp_d[5]  = '{0, 3, 3, 0, 3};

    initial begin
        int k, clr, en, fv, gd, gc, bad;

        // Reset state with run and full mask already applied
        reset = 1'b1; run = 1'b1; ch_mask = 8'hFF; window_len = 16'd3;
        pulses = '0; bus.res_ready = 1'b1;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_valid", bus.res_valid, 0);
        check("rst_sel", bus.cnt_sel, 0);
        check("rst_clear", bus.cnt_clear, 0);
        check("rst_enable", bus.cnt_enable, 0);
        check("rst_data", bus.res_data, 0);
        check("rst_ch", bus.res_ch, 0);
        reset = 1'b0;
        wait_clear(4);
        check("first_sel", bus.cnt_sel, 0);

        // Single slot on ch2, window 5
        run = 1'b0; ch_mask = 8'h04; window_len = 16'd5; pulses = 8'h04;
        do_reset();
        run = 1'b1;
        wait_clear(4);
        k = 1; clr = 1; en = 0; fv = 0; gd = 0; gc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            k++;
            if (bus.cnt_clear === 1'b1) clr++;
            if (bus.cnt_enable === 1'b1) en++;
            if (bus.res_valid === 1'b1 && fv == 0) begin
                fv = k; gd = int'(bus.res_data); gc = int'(bus.res_ch);
                run = 1'b0;
            end
        end
        check("single_clear_cycles", clr, 1);
        check("single_enable_cycles", en, 5);
        check("single_valid_cycle", fv, 8);
        check("single_res_ch", gc, 2);
        check("single_res_data", gd, 8'h07);

        // Rotation with wrap, back-to-back slots
        run = 1'b0; ch_mask = 8'b1000_0011; window_len = 16'd2; pulses = 8'b1000_0010;
        do_reset();
        run = 1'b1;
        wait_xfers(5, 60);
        run = 1'b0;
        if (mon_ch.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("rot_ch%0d", i), mon_ch[i], exp_ch[i]);
                check($sformatf("rot_data%0d", i), mon_data[i], exp_d[i]);
                if (i > 0) check($sformatf("rot_gap%0d", i), mon_cyc[i] - mon_cyc[i-1], 5);
            end
        end
        wait_idle(20);

        // Backpressure in HOLD
        ch_mask = 8'h10; window_len = 16'd3; pulses = 8'h10; bus.res_ready = 1'b0;
        do_reset();
        run = 1'b1;
        wait_valid(20);
        gd = int'(bus.res_data); gc = int'(bus.res_ch);
        check("bp_data", gd, 2);
        check("bp_ch", gc, 4);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.res_valid !== 1'b1 || int'(bus.res_data) != gd ||
                int'(bus.res_ch) != gc || bus.cnt_enable !== 1'b0) bad++;
        end
        check("bp_unstable_cycles", bad, 0);
        bus.res_ready = 1'b1;
        tick();
        check("bp_valid_after", bus.res_valid, 0);
        check("bp_clear_after", bus.cnt_clear, 1);
        check("bp_xfers", mon_ch.size(), 1);
        run = 1'b0;
        wait_idle(20);

        // Window 0 acts as 1
        ch_mask = 8'h01; window_len = 16'd0; pulses = 8'h01;
        do_reset();
        run = 1'b1;
        wait_clear(4);
        run = 1'b0;
        en = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cnt_enable === 1'b1) en++;
        end
        check("win0_enable_cycles", en, 1);
        check("win0_xfers", mon_ch.size(), 1);
        if (mon_data.size() >= 1) check("win0_data", mon_data[0], 1);

        // Empty mask keeps the block idle
        ch_mask = 8'h00; window_len = 16'd4;
        do_reset();
        run = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b0 || bus.cnt_clear !== 1'b0) bad++;
        end
        check("mask0_active_cycles", bad, 0);
        run = 1'b0;

        // run dropped during COUNT still delivers the slot
        ch_mask = 8'h08; window_len = 16'd6; pulses = 8'h08;
        do_reset();
        run = 1'b1;
        wait_clear(4);
        tick(2);
        run = 1'b0;
        wait_xfers(1, 20);
        if (mon_ch.size() >= 1) begin
            check("rundrop_ch", mon_ch[0], 3);
            check("rundrop_data", mon_data[0], 5);
        end
        wait_idle(10);
        tick(5);
        check("rundrop_xfers", mon_ch.size(), 1);

        // reset during COUNT aborts the slot
        ch_mask = 8'h20; window_len = 16'd6; pulses = 8'h20;
        do_reset();
        run = 1'b1;
        wait_clear(4);
        tick(2);
        check("abort_in_count", bus.cnt_enable, 1);
        reset = 1'b1;
        tick();
        check("abort_sel", bus.cnt_sel, 0);
        check("abort_clear", bus.cnt_clear, 0);
        check("abort_enable", bus.cnt_enable, 0);
        check("abort_valid", bus.res_valid, 0);
        check("abort_data", bus.res_data, 0);
        check("abort_ch", bus.res_ch, 0);
        check("abort_busy", busy, 0);
        run = 1'b0;
        tick();
        reset = 1'b0;
        tick(10);
        check("abort_xfers", mon_ch.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
